// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin controller for the shared RAM,
// keypad and display slaves. Each access runs IDLE -> ADDR -> DATA.
//
// Handshake: a master raises req with we/addr/wdata stable and holds
// them until its ack. gnt is high for the ADDR and DATA cycles of the
// granted transaction. ack is a one-cycle pulse in DATA, and rdata is
// valid in that cycle. It then holds until the next read ack to the
// same master.
module bus_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [11:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [11:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic [8:0]  ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        kp_a0,
    output logic        kp_rdclr,
    input  logic [15:0] kp_rdata,
    output logic [15:0] disp_data,
    output logic [7:0]  err_cnt,
    output logic [1:0]  dbg_state
);

    localparam logic [11:0] MEM_END       = 12'h1ff;
    localparam logic [11:0] KEYPAD_ADDR   = 12'h710;
    localparam logic [11:0] DISPLAY_ADDR  = 12'h730;
    localparam logic [15:0] DISP_RESET    = 16'hcccc;
    localparam logic [15:0] UNMAPPED_DATA = 16'hbebe;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t      state_q, state_d;
    // last_q is the most recently granted master. It also selects the
    // owner of the transaction in flight, because it is loaded on ADDR entry.
    logic        last_q;
    logic        sel;
    logic        any_req;
    logic [11:0] addr_q;
    logic        we_q;
    logic [15:0] wdata_q;
    logic [15:0] m0_rdata_q, m1_rdata_q;
    logic [15:0] disp_q;
    logic [7:0]  err_q;
    logic        in_addr, in_data, busy;
    logic        is_ram, is_kp_dat, is_kp, is_disp, unmapped;
    logic [15:0] rd_mux;

    assign any_req = m0_req | m1_req;
    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign busy    = in_addr | in_data;

    // Round-robin pick: a lone requester wins, and a tie goes to the master that was not granted last.
    always_comb begin
        sel = 1'b0;
        if (m0_req && m1_req) sel = ~last_q;
        else if (m1_req)      sel = 1'b1;
    end

    // Next-state logic for the fixed three-phase access sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ADDR;
            ADDR:    state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch the winner and its request on IDLE -> ADDR, so slave outputs ignore later input changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            addr_q  <= 12'h000;
            we_q    <= 1'b0;
            wdata_q <= 16'h0000;
        end else if (state_q == IDLE && any_req) begin
            last_q  <= sel;
            addr_q  <= sel ? m1_addr  : m0_addr;
            we_q    <= sel ? m1_we    : m0_we;
            wdata_q <= sel ? m1_wdata : m0_wdata;
        end
    end

    // Address decode of the latched address.
    always_comb begin
        is_ram    = (addr_q < MEM_END);
        is_kp_dat = (addr_q == KEYPAD_ADDR);
        is_kp     = is_kp_dat || (addr_q == (KEYPAD_ADDR + 12'd1));
        is_disp   = (addr_q == DISPLAY_ADDR);
        unmapped  = !(is_ram || is_kp || is_disp);
    end

    // Read-data source for the DATA cycle.
    always_comb begin
        rd_mux = UNMAPPED_DATA;
        if (is_ram)       rd_mux = ram_rdata;
        else if (is_kp)   rd_mux = kp_rdata;
        else if (is_disp) rd_mux = disp_q;
    end

    // Display register loads in ADDR. The unmapped counter also steps in ADDR and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= DISP_RESET;
            err_q  <= 8'h00;
        end else if (in_addr) begin
            if (we_q && is_disp)           disp_q <= wdata_q;
            if (unmapped && err_q != 8'hff) err_q <= err_q + 8'd1;
        end
    end

    // Capture read data for the owning master at the end of DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rdata_q <= 16'h0000;
            m1_rdata_q <= 16'h0000;
        end else if (in_data && !we_q) begin
            if (last_q) m1_rdata_q <= rd_mux;
            else        m0_rdata_q <= rd_mux;
        end
    end

    assign m0_gnt = busy & ~last_q;
    assign m1_gnt = busy &  last_q;
    assign m0_ack = in_data & ~last_q;
    assign m1_ack = in_data &  last_q;

    // Bypass during the ack cycle so rdata is already valid in that cycle.
    assign m0_rdata = (m0_ack && !we_q) ? rd_mux : m0_rdata_q;
    assign m1_rdata = (m1_ack && !we_q) ? rd_mux : m1_rdata_q;

    assign ram_addr  = addr_q[8:0];
    assign ram_wdata = wdata_q;
    assign ram_we    = in_addr & we_q & is_ram;
    assign kp_a0     = addr_q[0];
    assign kp_rdclr  = in_addr & ~we_q & is_kp_dat;
    assign disp_data = disp_q;
    assign err_cnt   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: cycle-level checks of bus_arbiter against a
// transaction-level reference model (arbitration rule, 3-cycle timing,
// memory map contents).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [11:0] m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [15:0] m0_rdata, m1_rdata;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic        kp_a0, kp_rdclr;
    logic [15:0] kp_rdata;
    logic [15:0] disp_data;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    logic [15:0] kp_dat = 16'h0005, kp_stat = 16'h0080;
    logic        ram_clr = 1'b1;
    logic [15:0] ram [0:511];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .kp_a0(kp_a0), .kp_rdclr(kp_rdclr), .kp_rdata(kp_rdata),
        .disp_data(disp_data), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 512; i++) ram[i] <= 16'h0000;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    assign kp_rdata = kp_a0 ? kp_stat : kp_dat;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
    } op_t;

    op_t q0[$];
    op_t q1[$];
    bit  act0 = 0, act1 = 0;
    bit  gaps = 0;

    // Reference model state.
    logic        last_m = 1'b1;
    int          free_at = 0;
    bit          txn_v = 0;
    int          txn_s = 0;
    bit          txn_g = 0;
    op_t         txn_op;
    logic [15:0] ref_mem [int];
    logic [15:0] disp_m = 16'hcccc;
    logic [7:0]  err_m = 8'h00;
    logic [15:0] exp_rd0 = 16'h0000, exp_rd1 = 16'h0000;

    function automatic bit is_ram_a(input logic [11:0] a);
        return a < 12'h1ff;
    endfunction

    function automatic bit mapped(input logic [11:0] a);
        return is_ram_a(a) || a == 12'h710 || a == 12'h711 || a == 12'h730;
    endfunction

    function automatic logic [15:0] ref_read(input logic [11:0] a);
        if (is_ram_a(a)) return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
        if (a == 12'h710) return kp_dat;
        if (a == 12'h711) return kp_stat;
        if (a == 12'h730) return disp_m;
        return 16'hbebe;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        act0 = 0; act1 = 0; txn_v = 0; free_at = 0;
        last_m = 1'b1; disp_m = 16'hcccc; err_m = 8'h00;
        exp_rd0 = 16'h0000; exp_rd1 = 16'h0000;
    endtask

    // One clock: check this cycle's outputs, retire, drive inputs, arbitrate.
    task automatic tick();
        logic e_g0, e_g1, e_a0, e_a1, e_we, e_clr;
        logic [15:0] rv;
        @(posedge clk); #1; cyc++;
        e_g0 = 0; e_g1 = 0; e_a0 = 0; e_a1 = 0; e_we = 0; e_clr = 0;
        if (txn_v && (cyc == txn_s + 1 || cyc == txn_s + 2)) begin
            e_g0 = !txn_g; e_g1 = txn_g;
        end
        if (txn_v && cyc == txn_s + 1) begin
            e_we  = txn_op.we && is_ram_a(txn_op.addr);
            e_clr = !txn_op.we && txn_op.addr == 12'h710;
            chk("ram_addr", {7'd0, ram_addr}, {7'd0, txn_op.addr[8:0]});
            if (txn_op.we) chk("ram_wdata", ram_wdata, txn_op.wdata);
        end
        if (txn_v && cyc == txn_s + 2) begin
            e_a0 = !txn_g; e_a1 = txn_g;
            if (txn_op.we) begin
                if (is_ram_a(txn_op.addr)) ref_mem[int'(txn_op.addr)] = txn_op.wdata;
                if (txn_op.addr == 12'h730) disp_m = txn_op.wdata;
            end else begin
                rv = ref_read(txn_op.addr);
                if (txn_g) exp_rd1 = rv; else exp_rd0 = rv;
            end
            if (!mapped(txn_op.addr) && err_m != 8'hff) err_m = err_m + 8'd1;
        end
        chk("m0_gnt", {15'd0, m0_gnt}, {15'd0, e_g0});
        chk("m1_gnt", {15'd0, m1_gnt}, {15'd0, e_g1});
        chk("m0_ack", {15'd0, m0_ack}, {15'd0, e_a0});
        chk("m1_ack", {15'd0, m1_ack}, {15'd0, e_a1});
        chk("ram_we", {15'd0, ram_we}, {15'd0, e_we});
        chk("kp_rdclr", {15'd0, kp_rdclr}, {15'd0, e_clr});
        chk("m0_rdata", m0_rdata, exp_rd0);
        chk("m1_rdata", m1_rdata, exp_rd1);
        chk("disp_data", disp_data, disp_m);
        chk("err_cnt", {8'd0, err_cnt}, {8'd0, err_m});
        if (txn_v && cyc == txn_s + 2) begin
            if (txn_g) begin void'(q1.pop_front()); act1 = 0; end
            else       begin void'(q0.pop_front()); act0 = 0; end
            txn_v = 0;
        end
        if (!act0 && q0.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) act0 = 1;
        if (!act1 && q1.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) act1 = 1;
        m0_req = act0;
        if (act0) begin m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; end
        m1_req = act1;
        if (act1) begin m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; end
        if (!txn_v && cyc >= free_at && (act0 || act1)) begin
            txn_g  = (act0 && act1) ? !last_m : act1;
            last_m = txn_g;
            txn_v  = 1; txn_s = cyc; free_at = cyc + 3;
            txn_op = txn_g ? q1[0] : q0[0];
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || txn_v) && n < limit) begin
            tick(); n++;
        end
        chk("drain_timeout", {15'd0, (n < limit)}, 16'd1);
    endtask

    task automatic push(input bit m, input logic we, input logic [11:0] a, input logic [15:0] d);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d;
        if (m) q1.push_back(o); else q0.push_back(o);
    endtask

    function automatic logic [11:0] rnd_addr();
        case ($urandom_range(0, 5))
            0: return 12'(($urandom_range(0, 15)));
            1: return 12'h1fe;
            2: return 12'h1ff;
            3: return 12'h710 + 12'($urandom_range(0, 1));
            4: return 12'h730;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        // Reset held for 3 cycles.
        rst_n = 1'b0; ram_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp", disp_data, 16'hcccc);
        chk("rst_err", {8'd0, err_cnt}, 16'd0);
        chk("rst_gnt_ack", {12'd0, m0_gnt, m1_gnt, m0_ack, m1_ack}, 16'd0);
        chk("rst_strobes", {14'd0, ram_we, kp_rdclr}, 16'd0);
        chk("rst_rdata0", m0_rdata, 16'h0000);
        chk("rst_rdata1", m1_rdata, 16'h0000);
        chk("rst_ram_addr", {7'd0, ram_addr}, 16'd0);
        chk("rst_ram_wdata", ram_wdata, 16'h0000);
        rst_n = 1'b1; ram_clr = 1'b0;
        repeat (4) tick();

        // m0 RAM write then read back.
        push(0, 1, 12'h005, 16'h1234);
        push(0, 0, 12'h005, 16'h0000);
        drain(40);

        // m1 display write and read back.
        push(1, 1, 12'h730, 16'hbeef);
        push(1, 0, 12'h730, 16'h0000);
        drain(40);

        // Contention: both saturating, grants alternate starting with m0.
        push(0, 1, 12'h020, 16'haaaa); push(0, 0, 12'h005, 16'h0000);
        push(1, 1, 12'h021, 16'h5555); push(1, 0, 12'h020, 16'h0000);
        drain(60);

        // Keypad data (clears ready) and status (no clear).
        kp_dat = 16'h0005; kp_stat = 16'h0081;
        push(0, 0, 12'h710, 16'h0000);
        push(0, 0, 12'h711, 16'h0000);
        push(1, 1, 12'h710, 16'h9999);
        drain(60);

        // Address boundaries: 1ff unmapped, 1fe is RAM.
        push(0, 0, 12'h1ff, 16'h0000);
        push(1, 1, 12'h1fe, 16'hface);
        push(0, 0, 12'h1fe, 16'h0000);
        drain(60);

        // Randomized traffic from both masters with random request gaps.
        kp_dat = 16'($urandom_range(0, 65535)); kp_stat = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 120; i++) begin
            push(0, 1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom_range(0, 65535)));
            push(1, 1'($urandom_range(0, 1)), rnd_addr(), 16'($urandom_range(0, 65535)));
        end
        gaps = 1;
        drain(3000);
        gaps = 0;

        // Saturate the unmapped-access counter.
        for (int i = 0; i < 300; i++) push(i % 2 == 1, 1'(i % 3 == 0), 12'h800 + 12'(i), 16'h0);
        drain(2000);
        chk("err_saturated", {8'd0, err_cnt}, 16'h00ff);

        // Reset during a RAM-write ADDR cycle: ram_we drops at once, no ack.
        push(0, 1, 12'h010, 16'h7777);
        begin
            int n = 0;
            while (!(txn_v && cyc == txn_s + 1) && n < 20) begin tick(); n++; end
            chk("abort_reach_addr", {15'd0, (n < 20)}, 16'd1);
        end
        chk("abort_ram_we_before", {15'd0, ram_we}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ram_we", {15'd0, ram_we}, 16'd0);
        chk("abort_gnt_ack", {12'd0, m0_gnt, m1_gnt, m0_ack, m1_ack}, 16'd0);
        chk("abort_disp", disp_data, 16'hcccc);
        chk("abort_err", {8'd0, err_cnt}, 16'd0);
        chk("abort_rdata0", m0_rdata, 16'h0000);
        model_reset();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
